// File: rtl/spike_window_counter.sv
// Rate-coded readout for the LIF layer: counts spikes per channel over a fixed
// window of enabled cycles, then publishes saturated counts, argmax and a valid strobe.
module spike_window_counter #(
    parameter int N_CH   = 4,
    parameter int CW     = 4,
    parameter int WINDOW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [N_CH-1:0]      spk,
    output logic [N_CH*CW-1:0]   count_o,
    output logic [2:0]           winner_o,
    output logic                 any_o,
    output logic                 valid_o
);

    localparam int              WCW     = $clog2(WINDOW);
    localparam logic [WCW-1:0]  LAST    = WCW'(WINDOW - 1);
    localparam logic [CW-1:0]   SAT_MAX = '1;

    logic [WCW-1:0]      r_wcnt;
    logic [CW-1:0]       r_acc [N_CH];
    logic [N_CH*CW-1:0]  r_count;
    logic [2:0]          r_winner;
    logic                r_any;
    logic                r_valid;

    logic [CW-1:0]       w_sum [N_CH];
    logic [N_CH*CW-1:0]  w_sum_flat;
    logic [CW-1:0]       w_best;
    logic [2:0]          w_winner;
    logic                w_any;
    logic                w_last;

    assign w_last = (r_wcnt == LAST);

    // Saturating next-count per channel; this is also the final value at window end,
    // so a spike in the last enabled cycle is always included.
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_sum_flat = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum[i] = (spk[i] && (r_acc[i] != SAT_MAX)) ? r_acc[i] + CW'(1) : r_acc[i];
            w_sum_flat[i*CW +: CW] = w_sum[i];
        end
    end

    // Strict '>' keeps the lowest index on ties; all-zero leaves the winner at 0.
    always_comb begin
        w_best   = w_sum[0];
        w_winner = 3'd0;
        w_any    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_sum[i] > w_best) begin
                w_best   = w_sum[i];
                w_winner = 3'(i);
            end
            w_any = w_any | (w_sum[i] != '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the accumulator array is reset explicitly; an aborted window
    // must never leak partial counts into the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wcnt   <= '0;
            for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
            r_count  <= '0;
            r_winner <= '0;
            r_any    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clear) begin
                r_wcnt <= '0;
                for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
            end else if (en) begin
                if (w_last) begin
                    r_wcnt   <= '0;
                    for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
                    r_count  <= w_sum_flat;
                    r_winner <= w_winner;
                    r_any    <= w_any;
                    r_valid  <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + WCW'(1);
                    for (int i = 0; i < N_CH; i++) r_acc[i] <= w_sum[i];
                end
            end
        end
    end

    assign count_o  = r_count;
    assign winner_o = r_winner;
    assign any_o    = r_any;
    assign valid_o  = r_valid;

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter (N_CH=4, CW=4, WINDOW=16) with
// hand-computed expected counts, winners and strobe timing.
module tb_spike_window_counter;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         clear;
    logic [3:0]   spk;
    logic [15:0]  count_o;
    logic [2:0]   winner_o;
    logic         any_o;
    logic         valid_o;

    int n_cmp;
    int n_err;

    spike_window_counter #(.N_CH(4), .CW(4), .WINDOW(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clear    (clear),
        .spk      (spk),
        .count_o  (count_o),
        .winner_o (winner_o),
        .any_o    (any_o),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cycle(input logic e, input logic c, input logic [3:0] s);
        en    = e;
        clear = c;
        spk   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [15:0] cnt,
                                input logic [2:0] win, input logic any);
        check({tag, "_valid"},  valid_o,  1'b1);
        check({tag, "_count"},  count_o,  cnt);
        check({tag, "_winner"}, winner_o, win);
        check({tag, "_any"},    any_o,    any);
    endtask

    // 16 enabled cycles; channel i spikes in the last n_i of them. An optional
    // en=0 gap (with all spikes high, which must be ignored) is inserted after
    // gap_at enabled cycles; at the end of the gap count_o must still be hold_cnt.
    task automatic run_window(input string tag, input int n0, input int n1, input int n2,
                              input int n3, input int gap_at, input int gap_len,
                              input logic [15:0] hold_cnt);
        int  n [4];
        bit  early;
        logic [3:0] s;
        n = '{n0, n1, n2, n3};
        early = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (gap_len > 0 && c == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    cycle(1'b0, 1'b0, 4'hF);
                    if (valid_o) early = 1'b1;
                end
                check({tag, "_gap_hold"}, count_o, hold_cnt);
            end
            for (int i = 0; i < 4; i++) s[i] = (c >= 16 - n[i]);
            cycle(1'b1, 1'b0, s);
            if (c < 15 && valid_o) early = 1'b1;
        end
        check({tag, "_early_valid"}, early, 1'b0);
    endtask

    initial begin
        bit early;
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        en      = 1'($urandom_range(0, 1));
        clear   = 1'b0;
        spk     = 4'($urandom);

        // Outputs cleared by reset alone, before any clock edge.
        #3;
        check("rst_count",  count_o,  16'h0);
        check("rst_winner", winner_o, 3'd0);
        check("rst_any",    any_o,    1'b0);
        check("rst_valid",  valid_o,  1'b0);
        cycle(1'b1, 1'b0, 4'hF);
        cycle(1'b1, 1'b0, 4'hA);
        check("rst_hold_count", count_o, 16'h0);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 4'h0);

        // Saturation: ch0 spikes 16 times, clamps at 15.
        run_window("sat", 16, 0, 0, 0, 0, 0, 16'h0);
        check_result("sat", 16'h000F, 3'd0, 1'b1);

        // Next window restarts from zero.
        run_window("restart", 3, 0, 0, 0, 0, 0, 16'h0);
        check_result("restart", 16'h0003, 3'd0, 1'b1);

        // Tie between ch1 and ch2 goes to the lower index.
        run_window("tie", 0, 5, 5, 3, 0, 0, 16'h0);
        check_result("tie", 16'h3550, 3'd1, 1'b1);

        // en=0 for 10 cycles at wcnt=7: 26 cycles total, same counts as without gap.
        run_window("gap", 2, 4, 1, 0, 7, 10, 16'h3550);
        check_result("gap", 16'h0142, 3'd1, 1'b1);

        // Clear at wcnt=8 after a ch0=15 result: outputs hold, window restarts.
        run_window("pre_clr", 16, 0, 0, 0, 0, 0, 16'h0);
        check_result("pre_clr", 16'h000F, 3'd0, 1'b1);
        early = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 1'b0, 4'hF);
            if (valid_o) early = 1'b1;
        end
        cycle(1'b1, 1'b1, 4'hF);
        check("clr_pre_valid", early, 1'b0);
        check("clr_valid",  valid_o,  1'b0);
        check("clr_count",  count_o,  16'h000F);
        check("clr_winner", winner_o, 3'd0);
        check("clr_any",    any_o,    1'b1);
        run_window("post_clr", 1, 2, 0, 7, 0, 0, 16'h0);
        check_result("post_clr", 16'h7021, 3'd3, 1'b1);

        // Silent window still strobes, with zero results.
        run_window("silent", 0, 0, 0, 0, 0, 0, 16'h0);
        check_result("silent", 16'h0000, 3'd0, 1'b0);
        cycle(1'b0, 1'b0, 4'hF);
        check("strobe_one_cycle", valid_o, 1'b0);
        check("idle_hold_count",  count_o, 16'h0000);

        // Load a nonzero result, then abort a window with async reset at wcnt=12.
        run_window("pre_abort", 0, 0, 9, 0, 0, 0, 16'h0);
        check_result("pre_abort", 16'h0900, 3'd2, 1'b1);
        early = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 1'b0, 4'hF);
            if (valid_o) early = 1'b1;
        end
        check("abort_pre_valid", early, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_count",  count_o,  16'h0);
        check("abort_winner", winner_o, 3'd0);
        check("abort_any",    any_o,    1'b0);
        check("abort_valid",  valid_o,  1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        // The aborted window's remaining 4 cycles must not publish anything.
        run_window("after_abort", 0, 1, 0, 0, 0, 0, 16'h0);
        check_result("after_abort", 16'h0010, 3'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spike_window_counter.md
Name: spike_window_counter

Overview:
- Downstream readout stage for the LIF neuron layer. Takes the per-neuron spike outputs and counts spikes per channel over a fixed window of enabled clock cycles.
- At the end of each window it publishes the saturated per-channel counts and the index of the most active channel, plus a one-cycle valid strobe.
- Converts the layer's spike trains into rate-coded results that the top level or host logic can read.

Parameters:
- N_CH, 4, number of spike input channels (1..8).
- CW, 4, width of each per-channel count; counts saturate at 2^CW-1.
- WINDOW, 16, window length in enabled cycles (2..65535).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; when low, all window state freezes.
- clear  input  1  synchronous restart of the current window.
- spk  input  N_CH  spike inputs, one per channel; sampled only when en=1.
- count_o  output  N_CH*CW  latched counts; channel i occupies bits [i*CW +: CW].
- winner_o  output  3  index of the channel with the highest latched count.
- any_o  output  1  1 when at least one latched count is nonzero.
- valid_o  output  1  one-cycle strobe when new results are latched.

Behaviour:
- Reset: reset is asynchronous, active-low (reset_n). While reset_n=0:
  - window counter wcnt=0 and all accumulators acc[i]=0;
  - count_o=0, winner_o=0, any_o=0, valid_o=0.
- Priority per clock edge: reset, then clear, then en.
- clear=1 (regardless of en):
  - wcnt and all acc[i] go to 0; valid_o=0 next cycle;
  - count_o, winner_o and any_o hold their previous values;
  - spikes present in the clear cycle are discarded.
- en=0 and clear=0: wcnt, acc and all outputs hold; valid_o=0.
- en=1, clear=0, wcnt<WINDOW-1:
  - acc[i] <= sat(acc[i]+spk[i]), where sat() clamps at 2^CW-1 and never wraps;
  - wcnt <= wcnt+1; valid_o=0.
- en=1, clear=0, wcnt==WINDOW-1 (window end):
  - final[i] = sat(acc[i]+spk[i]), so the spike in the last cycle is included;
  - count_o <= final, winner_o <= argmax(final), any_o <= OR of (final[i]!=0), valid_o <= 1;
  - acc[i] <= 0 and wcnt <= 0; the next window starts on the following cycle with no gap.
- valid_o is high for exactly one cycle after each window end; it is never high two cycles in a row unless WINDOW=... (not possible, since WINDOW>=2).
- Latency: results appear one clock after the edge that samples the window's last enabled cycle. They are visible in the same cycle valid_o is high.
- argmax:
  - ties go to the lowest index;
  - if all counts are 0, winner_o=0 and any_o=0;
  - winner_o upper bits are 0 when N_CH<8.
- wcnt is wide enough for WINDOW-1; no other wrap-around exists.
- Asynchronous reset mid-window aborts the window; no partial result is published.

Test Plan:
- Reset: reset_n=0 with random spk/en -> all outputs 0 immediately, with no clock edge needed. Release reset -> valid_o stays 0 for the first 15 enabled cycles.
- Saturation: WINDOW=16, CW=4, spk=4'b0001 held for 16 en cycles -> valid_o high one cycle; count_o ch0=15, ch1..3=0; winner_o=0; any_o=1. Next window counts from 0.
- Tie/winner: in one window, ch1 gets 5 spikes, ch2 gets 5, ch3 gets 3, ch0 gets 0, with ch2's last spike in the final cycle -> count_o={3,5,5,0} (ch3..ch0), winner_o=1, any_o=1.
- Enable gating: en=0 for 10 cycles at wcnt=7 -> no state change during the gap; valid_o asserts 26 cycles after the window start instead of 16, with identical counts.
- Clear: clear=1 at wcnt=8 with prior results count ch0=15 -> outputs hold at previous values; no valid at the original window end; next valid_o exactly 16 en cycles after the clear cycle.
- Silence and abort:
  - window with spk=0 throughout -> count_o=0, winner_o=0, any_o=0, valid_o still pulses;
  - reset_n low at wcnt=12 -> outputs cleared and no valid_o for that window.
